// File: rtl/pixel_feeder_pkg.sv
// Shared video definitions for the pixel feeder: pixel packing widths,
// default frame geometry and the controller state encoding.
package pixel_feeder_pkg;

  localparam int COMP_W       = 10;
  localparam int PIX_W        = 3 * COMP_W;
  localparam int OUT_W        = 32;
  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_UNDERRUN,
    ST_DONE
  } feeder_state_t;

  function automatic logic [OUT_W-1:0] pack_pixel(input logic [PIX_W-1:0] pix);
    return {{(OUT_W-PIX_W){1'b0}}, pix};
  endfunction

endpackage

// File: rtl/pixel_feeder_if.sv
// Pixel write handshake (camera side) and request/response (consumer side)
// of the pixel feeder.
interface pixel_feeder_if;
  import pixel_feeder_pkg::*;

  logic             i_wr_valid;
  logic [PIX_W-1:0] i_wr_data;
  logic             o_wr_ready;
  logic             i_req;
  logic             o_valid;
  logic [OUT_W-1:0] o_data;

  modport master (
    output i_wr_valid, i_wr_data, i_req,
    input  o_wr_ready, o_valid, o_data
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_req,
    output o_wr_ready, o_valid, o_data
  );

endinterface

// File: rtl/pixel_feeder_fifo.sv
// Synchronous pixel FIFO with flush; head word is visible combinationally.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 30
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok     = i_wr_en && (o_level != LW'(DEPTH));
  assign rd_ok     = i_rd_en && (o_level != '0);
  assign o_rd_data = mem[rd_ptr];

  // Storage carries no reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_ok && !i_flush) mem[wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else if (i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   o_level <= o_level + 1'b1;
        2'b01:   o_level <= o_level - 1'b1;
        default: o_level <= o_level;
      endcase
    end
  end

endmodule

// File: rtl/pixel_feeder.sv
// Buffers camera pixels and serves them to a request-driven consumer,
// tracking frame position and flagging underruns.
//   state    | meaning
//   IDLE     | no frame yet; writes dropped, requests return black
//   FILL     | storing pixels until the FIFO reaches PREFILL
//   STREAM   | each request pops one pixel
//   UNDERRUN | request hit an empty FIFO; black until next frame start
//   DONE     | last pixel of the frame served; black until next frame start
module pixel_feeder
  import pixel_feeder_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int PREFILL  = 8,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_frame_start,
  pixel_feeder_if.slave          bus,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_underrun,
  output logic                   o_frame_done
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
  localparam logic [CW-1:0] COL_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(V_ACTIVE - 1);

  feeder_state_t    state;
  logic [CW-1:0]    col, col_nxt;
  logic [RW-1:0]    row, row_nxt;
  logic [PIX_W-1:0] head;
  logic             last_px;
  logic             serve;
  logic             fifo_wr, fifo_rd, fifo_flush;

  assign bus.o_wr_ready = (state == ST_FILL || state == ST_STREAM) ? (o_level < DEPTH_L) : 1'b1;

  assign last_px    = (col == COL_LAST) && (row == ROW_LAST);
  assign serve      = bus.i_req && !i_frame_start &&
                      (state == ST_STREAM || state == ST_UNDERRUN);
  assign fifo_wr    = bus.i_wr_valid && bus.o_wr_ready && !i_frame_start &&
                      (state == ST_FILL || state == ST_STREAM);
  assign fifo_rd    = bus.i_req && !i_frame_start && (state == ST_STREAM);
  // Serving the final pixel enters DONE, which starts with an empty FIFO.
  assign fifo_flush = i_frame_start || (fifo_rd && (o_level != '0) && last_px);

  always_comb begin
    col_nxt = col + 1'b1;
    row_nxt = row;
    if (col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row == ROW_LAST) ? '0 : row + 1'b1;
    end
  end

  pixel_fifo #(.DEPTH(DEPTH), .WIDTH(PIX_W)) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (fifo_flush),
    .i_wr_en   (fifo_wr),
    .i_wr_data (bus.i_wr_data),
    .i_rd_en   (fifo_rd),
    .o_rd_data (head),
    .o_level   (o_level)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      col          <= '0;
      row          <= '0;
      bus.o_valid  <= 1'b0;
      bus.o_data   <= '0;
      o_underrun   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      bus.o_valid  <= bus.i_req;
      bus.o_data   <= '0;
      o_frame_done <= 1'b0;
      if (i_frame_start) begin
        state      <= ST_FILL;
        col        <= '0;
        row        <= '0;
        o_underrun <= 1'b0;
      end else begin
        if (serve) begin
          col <= col_nxt;
          row <= row_nxt;
        end
        case (state)
          ST_FILL: begin
            if (o_level >= PREFILL_L) state <= ST_STREAM;
          end
          ST_STREAM: begin
            if (bus.i_req) begin
              if (o_level == '0) begin
                o_underrun <= 1'b1;
                state      <= ST_UNDERRUN;
              end else begin
                bus.o_data <= pack_pixel(head);
                if (last_px) begin
                  o_frame_done <= 1'b1;
                  state        <= ST_DONE;
                end
              end
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_feeder.sv
// Scoreboard bench for pixel_feeder: requests push expected responses, a
// negedge monitor pops them whenever o_valid is seen.
module tb_pixel_feeder;
  import pixel_feeder_pkg::*;

  typedef struct {
    logic [31:0] d;
    logic        fd;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic fs_a = 1'b0;
  logic fs_b = 1'b0;
  logic [4:0] level_a, level_b;
  logic underrun_a, underrun_b, done_a, done_b;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic [29:0] mq[$];
  exp_t e;

  always #5 i_clk = ~i_clk;

  pixel_feeder_if bus_a ();
  pixel_feeder_if bus_b ();

  // Small frame so a complete frame fits in a short run.
  pixel_feeder #(.DEPTH(16), .PREFILL(8), .H_ACTIVE(16), .V_ACTIVE(4)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(fs_a), .bus(bus_a.slave),
    .o_level(level_a), .o_underrun(underrun_a), .o_frame_done(done_a));

  pixel_feeder #(.DEPTH(16), .PREFILL(17)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(fs_b), .bus(bus_b.slave),
    .o_level(level_b), .o_underrun(underrun_b), .o_frame_done(done_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (bus_a.o_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("o_data", bus_a.o_data, e.d);
          chk("o_frame_done", {31'd0, done_a}, {31'd0, e.fd});
        end
      end else if (done_a) begin
        chk("frame_done_without_valid", 32'd1, 32'd0);
      end
    end
  end

  task automatic drive(input logic fs, input logic wv, input logic [29:0] wd,
                       input logic rq, input logic [31:0] ed, input logic efd);
    fs_a = fs;
    bus_a.i_wr_valid = wv;
    bus_a.i_wr_data = wd;
    bus_a.i_req = rq;
    if (rq) sb.push_back('{ed, efd});
    @(posedge i_clk);
    #1;
    fs_a = 1'b0;
    bus_a.i_wr_valid = 1'b0;
    bus_a.i_wr_data = '0;
    bus_a.i_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] px;
    int exp_lvl;
    bus_a.i_wr_valid = 1'b0; bus_a.i_wr_data = '0; bus_a.i_req = 1'b0;
    bus_b.i_wr_valid = 1'b0; bus_b.i_wr_data = '0; bus_b.i_req = 1'b0;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_level", level_a, 0);
    chk("rst_valid", bus_a.o_valid, 0);
    chk("rst_data", bus_a.o_data, 0);
    chk("rst_underrun", underrun_a, 0);
    chk("rst_frame_done", done_a, 0);
    chk("rst_wr_ready", bus_a.o_wr_ready, 1);
    i_rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // IDLE: requests black, writes discarded
    drive(0, 1, 30'h3ff, 1, 32'h0, 0);
    chk("idle_level", level_a, 0);
    chk("idle_wr_ready", bus_a.o_wr_ready, 1);

    // Prefill 8 then stream three pixels
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) drive(0, 1, 30'(i), 0, 0, 0);
    chk("prefill_level", level_a, 8);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) drive(0, 0, 0, 1, 32'(i), 0);
    chk("after3_level", level_a, 5);

    // FILL with level 4: request returns black and pops nothing
    drive(1, 0, 0, 0, 0, 0);
    chk("fs_flush_level", level_a, 0);
    mq.delete();
    for (int i = 1; i <= 4; i++) begin
      px = 30'h40 + 30'(i);
      mq.push_back(px);
      drive(0, 1, px, 0, 0, 0);
    end
    drive(0, 0, 0, 1, 32'h0, 0);
    chk("fill_req_level", level_a, 4);

    // Same frame: complete 16x4 frame with continuous writes
    for (int i = 5; i <= 8; i++) begin
      px = 30'h40 + 30'(i);
      mq.push_back(px);
      drive(0, 1, px, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 64; k++) begin
      px = 30'h300 + 30'(k);
      e.d = {2'b00, mq.pop_front()};
      mq.push_back(px);
      drive(0, 1, px, 1, e.d, k == 63);
      if (k == 30) chk("wr_pop_level", level_a, 8);
    end
    chk("done_level", level_a, 0);
    drive(0, 0, 0, 1, 32'h0, 0);
    drive(0, 1, 30'h1, 1, 32'h0, 0);
    chk("done_wr_level", level_a, 0);
    chk("done_wr_ready", bus_a.o_wr_ready, 1);

    // Drain to empty, then underrun
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 30'h11 + 30'(i), 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 32'h11 + 32'(i), 0);
    chk("drained_level", level_a, 0);
    chk("pre_underrun", underrun_a, 0);
    drive(0, 0, 0, 1, 32'h0, 0);
    chk("underrun_set", underrun_a, 1);
    chk("underrun_wr_ready", bus_a.o_wr_ready, 1);
    drive(0, 1, 30'h77, 0, 0, 0);
    chk("underrun_wr_level", level_a, 0);
    drive(0, 0, 0, 1, 32'h0, 0);
    chk("underrun_sticky", underrun_a, 1);
    drive(1, 1, 30'h55, 1, 32'h0, 0);
    chk("fs_clear_underrun", underrun_a, 0);
    chk("fs_override_level", level_a, 0);

    // Reset mid-STREAM at level 10
    for (int i = 0; i < 10; i++) drive(0, 1, 30'h20 + 30'(i), 0, 0, 0);
    chk("pre_rst_level", level_a, 10);
    drive(0, 1, 30'h2a, 1, 32'h20, 0);
    chk("wr_pop_same_level", level_a, 10);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus_a.o_valid, 0);
    chk("mid_rst_data", bus_a.o_data, 0);
    chk("mid_rst_level", level_a, 0);
    chk("mid_rst_underrun", underrun_a, 0);
    chk("mid_rst_frame_done", done_a, 0);
    chk("mid_rst_wr_ready", bus_a.o_wr_ready, 1);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    drive(0, 1, 30'h9, 1, 32'h0, 0);
    chk("post_rst_level", level_a, 0);

    // PREFILL beyond DEPTH: FIFO saturates at 16 with ready low
    fs_b = 1'b1;
    @(posedge i_clk);
    #1;
    fs_b = 1'b0;
    bus_b.i_wr_valid = 1'b1;
    bus_b.i_wr_data = 30'h123;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk);
      #1;
      exp_lvl = (i + 1 > 16) ? 16 : i + 1;
      chk("b_level", level_b, 32'(exp_lvl));
      chk("b_wr_ready", bus_b.o_wr_ready, (exp_lvl < 16) ? 32'd1 : 32'd0);
    end
    bus_b.i_wr_valid = 1'b0;

    repeat (3) @(posedge i_clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_feeder.md
PIXEL_FEEDER -- requirements
Module: pixel_feeder

Interface
REQ-001 Parameter DEPTH, 16, FIFO entries (power of two).
REQ-002 Parameter PREFILL, 8, FIFO level needed to leave FILL.
REQ-003 Parameter H_ACTIVE, 800, pixels per line.
REQ-004 Parameter V_ACTIVE, 600, lines per frame.
REQ-005 The block SHALL use one clock and an asynchronous active-low reset. Ports: i_clk  in  1  clock; i_rst_n  in  1  async active-low reset.
REQ-006 i_frame_start  in  1  single-cycle pulse starting a new camera frame.
REQ-007 i_wr_valid  in  1  upstream pixel valid; i_wr_data  in  30  {R,G,B}, 10 bits each; o_wr_ready  out  1  pixel accepted when valid&&ready.
REQ-008 i_req  in  1  consumer pixel request; o_valid  out  1  data valid, one cycle after i_req; o_data  out  32  {2'b0,R,G,B}.
REQ-009 o_level  out  $clog2(DEPTH)+1  FIFO occupancy; o_underrun  out  1  sticky error flag; o_frame_done  out  1  one-cycle pulse.

Function
REQ-010 States: IDLE, FILL, STREAM, UNDERRUN, DONE; reset state IDLE.
REQ-011 IDLE: o_wr_ready=1, writes discarded, requests return black; i_frame_start -> FILL.
REQ-012 i_frame_start in any state SHALL flush FIFO (level 0), clear col/row counters and o_underrun, enter FILL; it overrides a same-cycle write or request (request returns black, write discarded).
REQ-013 FILL: writes stored when level<DEPTH; requests return black without popping and without advancing counters; level>=PREFILL -> STREAM.
REQ-014 STREAM: i_req pops head; o_data <= {2'b0,head} next cycle, o_valid=1.
REQ-015 STREAM with i_req and level==0: o_data black, o_underrun<=1, -> UNDERRUN.
REQ-016 UNDERRUN: writes accepted and discarded (o_wr_ready=1), requests return black, counters still advance; only i_frame_start exits.
REQ-017 Col counter 0..H_ACTIVE-1 increments per served request in STREAM/UNDERRUN; wrap to 0 increments row.
REQ-018 Request serving pixel (H_ACTIVE-1, V_ACTIVE-1): o_frame_done pulses same cycle as that pixel's o_valid; -> DONE.
REQ-019 DONE: writes discarded with o_wr_ready=1; requests return black; level held at 0 (flush on entry).
REQ-020 o_wr_ready = (level<DEPTH) in FILL/STREAM; simultaneous write and pop at any level SHALL leave level unchanged; write at full impossible (ready low).
REQ-021 o_valid SHALL equal registered i_req in every state (latency exactly 1, no bubbles); black = 32'h0.
REQ-022 Pointers wrap modulo DEPTH; level never exceeds DEPTH nor underflows.

Reset
REQ-023 Reset asserted: state IDLE, level 0, pointers 0, counters 0, o_valid 0, o_data 0, o_underrun 0, o_frame_done 0, o_wr_ready 1.
REQ-024 Reset mid-frame SHALL discard FIFO contents; no output pulse generated by reset.
REQ-025 FIFO storage array need not be reset.

Structure
REQ-026 State enum, H_ACTIVE/V_ACTIVE defaults and pixel packing widths SHALL live in the shared video package.
REQ-027 FIFO SHALL be one sub-module, pixel_fifo (sync, DEPTH x 30, flush input, level output); FSM and counters in pixel_feeder.

Verification
REQ-028 Frame start, write 8 pixels 0x0000001..0x0000008 -> STREAM; 3 requests -> o_data 0x0000001,2,3 each one cycle after req, o_level 5.
REQ-029 FILL with level 4, issue request -> o_valid=1, o_data=0, level stays 4, col counter 0.
REQ-030 STREAM, drain to 0, request -> o_data=0, o_underrun=1, state UNDERRUN; next i_frame_start -> o_underrun=0, level 0.
REQ-031 Hold i_wr_valid 20 cycles in FILL with no requests (PREFILL=17 override) -> o_wr_ready low at level 16, level never 17.
REQ-032 Stream full 800x600 frame with continuous writes -> exactly one o_frame_done, coincident with 480000th o_valid; following requests return 0.
REQ-033 Assert i_rst_n low mid-STREAM with level 10 -> all outputs reset values immediately; after release, state IDLE, level 0.
